// File: rtl/mips_pkg.sv
// mips_pkg: shared defaults and arbiter state encoding for the MIPS memory arbiter.
package mips_pkg;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int STARVE_LIMIT = 4;
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    LOAD  = 2'd2
  } arb_state_t;
endpackage

// File: rtl/mips_arb_prio.sv
// mips_arb_prio: RUN-state data-over-fetch priority with a saturating fetch starvation counter.
module mips_arb_prio #(
  parameter int STARVE_LIMIT = mips_pkg::STARVE_LIMIT
) (
  input  logic clk1,
  input  logic rst,
  input  logic i_en,
  input  logic i_f_req,
  input  logic i_d_req,
  output logic o_f_gnt,
  output logic o_d_gnt
);
  localparam int CW = $clog2(STARVE_LIMIT + 2);
  logic [CW-1:0] r_starve;
  logic w_starved;
  always_comb begin
    w_starved = (r_starve == CW'(STARVE_LIMIT));
    o_f_gnt = i_en & i_f_req & (w_starved | ~i_d_req);
    o_d_gnt = i_en & i_d_req & ~(w_starved & i_f_req);
  end
  // Counts every denied fetch cycle, whatever the arbiter state, so a fetch
  // blocked through a load phase wins immediately on return to RUN.
  always_ff @(posedge clk1) begin
    if (rst) r_starve <= '0;
    else if (!i_f_req || o_f_gnt) r_starve <= '0;
    else if (!w_starved) r_starve <= r_starve + CW'(1);
  end
endmodule

// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter: shares one memory port between fetch, data and program-loader requesters.
module mips_mem_arbiter #(
  parameter int ADDR_W = mips_pkg::ADDR_W,
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int STARVE_LIMIT = mips_pkg::STARVE_LIMIT
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              cpu_halted,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              f_gnt,
  output logic              d_gnt,
  output logic              ld_gnt,
  output logic              f_rvalid,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              stall_if,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  import mips_pkg::*;
  arb_state_t r_state, w_next;
  logic r_f_pend, r_d_pend;
  logic [DATA_W-1:0] r_rdata;
  logic w_run_en, w_f_win, w_d_win, w_pend;
  assign w_run_en = ~rst & (r_state == RUN) & ~cpu_halted;
  mips_arb_prio #(.STARVE_LIMIT(STARVE_LIMIT)) u_prio (
    .clk1(clk1),
    .rst(rst),
    .i_en(w_run_en),
    .i_f_req(f_req),
    .i_d_req(d_req),
    .o_f_gnt(w_f_win),
    .o_d_gnt(w_d_win)
  );
  always_comb begin
    w_pend = r_f_pend | r_d_pend;
    f_gnt = w_f_win;
    d_gnt = w_d_win;
    ld_gnt = ~rst & (r_state == LOAD) & ld_req;
    mem_en = f_gnt | d_gnt | ld_gnt;
    mem_we = ld_gnt | (d_gnt & d_we);
    mem_addr = ld_gnt ? ld_addr : d_gnt ? d_addr : f_gnt ? f_addr : '0;
    mem_wdata = ld_gnt ? ld_wdata : (d_gnt & d_we) ? d_wdata : '0;
    stall_if = f_req & ~f_gnt;
    f_rvalid = r_f_pend & ~rst;
    d_rvalid = r_d_pend & ~rst;
    // Memory read data arrives in the cycle after issue; pass it straight
    // through then and hold the last value otherwise.
    rdata = rst ? '0 : w_pend ? mem_rdata : r_rdata;
    w_next = r_state == RUN ? (cpu_halted ? (w_pend ? DRAIN : LOAD) : RUN)
           : r_state == DRAIN ? LOAD
           : (cpu_halted ? LOAD : RUN);
  end
  always_ff @(posedge clk1) begin
    if (rst) begin
      r_state <= RUN;
      r_f_pend <= 1'b0;
      r_d_pend <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      r_f_pend <= f_gnt;
      r_d_pend <= d_gnt & ~d_we;
      if (w_pend) r_rdata <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_mips_mem_arbiter.sv
// tb_mips_mem_arbiter: directed scenarios checked against a cycle-level behavioural model plus literal spot checks.
module tb_mips_mem_arbiter;
  localparam int LIM = 4;
  logic clk1 = 1'b0;
  logic rst, cpu_halted, f_req, d_req, d_we, ld_req;
  logic [9:0] f_addr, d_addr, ld_addr;
  logic [31:0] d_wdata, ld_wdata;
  logic f_gnt, d_gnt, ld_gnt, f_rvalid, d_rvalid, stall_if, mem_en, mem_we;
  logic [31:0] rdata, mem_wdata, mem_rdata;
  logic [9:0] mem_addr;
  int n_vec = 0, n_err = 0;

  always #5 clk1 = ~clk1;

  mips_mem_arbiter dut (
    .clk1(clk1), .rst(rst), .cpu_halted(cpu_halted),
    .f_req(f_req), .f_addr(f_addr),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .f_gnt(f_gnt), .d_gnt(d_gnt), .ld_gnt(ld_gnt),
    .f_rvalid(f_rvalid), .d_rvalid(d_rvalid), .rdata(rdata),
    .stall_if(stall_if), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] seed(int a);
    return a == 5 ? 32'h00222000 : (32'h5a000000 | 32'(a));
  endfunction

  logic [31:0] mem [0:1023];
  always @(posedge clk1) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) mem[i] <= seed(i);
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  // Model: mode 0=running, 1=draining, 2=loading; pend 0=none, 1=fetch, 2=data.
  int m_mode = 0, m_starve = 0, m_pend = 0;
  logic [31:0] m_pdata = '0, m_last = '0;
  logic [31:0] m_mem [0:1023];
  always @(negedge clk1) begin
    logic e_f, e_d, e_ld, e_en, e_we;
    logic [31:0] e_addr, e_wdata, e_rdata;
    int old_pend;
    e_f = 0; e_d = 0; e_ld = 0;
    if (!rst && m_mode == 0 && !cpu_halted) begin
      if (f_req && (m_starve == LIM || !d_req)) e_f = 1;
      else if (d_req) e_d = 1;
    end
    if (!rst && m_mode == 2) e_ld = ld_req;
    e_en = e_f | e_d | e_ld;
    e_we = e_ld | (e_d & d_we);
    e_addr = e_ld ? 32'(ld_addr) : e_d ? 32'(d_addr) : 32'(f_addr);
    e_wdata = e_ld ? ld_wdata : d_wdata;
    e_rdata = rst ? 32'h0 : (m_pend != 0) ? m_pdata : m_last;
    chk("f_gnt", 32'(f_gnt), 32'(e_f));
    chk("d_gnt", 32'(d_gnt), 32'(e_d));
    chk("ld_gnt", 32'(ld_gnt), 32'(e_ld));
    chk("mem_en", 32'(mem_en), 32'(e_en));
    chk("stall_if", 32'(stall_if), 32'(f_req & ~e_f));
    chk("f_rvalid", 32'(f_rvalid), 32'(!rst && m_pend == 1));
    chk("d_rvalid", 32'(d_rvalid), 32'(!rst && m_pend == 2));
    chk("rdata", rdata, e_rdata);
    if (e_en) begin
      chk("mem_we", 32'(mem_we), 32'(e_we));
      chk("mem_addr", 32'(mem_addr), e_addr);
      if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
    end
    if (rst) begin
      m_mode = 0; m_starve = 0; m_pend = 0; m_last = '0;
      for (int i = 0; i < 1024; i++) m_mem[i] = seed(i);
    end else begin
      old_pend = m_pend;
      if (m_pend != 0) m_last = m_pdata;
      m_starve = (f_req && !e_f) ? (m_starve < LIM ? m_starve + 1 : LIM) : 0;
      m_pend = 0;
      if (e_en && !e_we) begin
        m_pend = e_f ? 1 : 2;
        m_pdata = m_mem[e_addr[9:0]];
      end
      if (e_en && e_we) m_mem[e_addr[9:0]] = e_wdata;
      if (m_mode == 0 && cpu_halted) m_mode = (old_pend != 0) ? 1 : 2;
      else if (m_mode == 1) m_mode = 2;
      else if (m_mode == 2 && !cpu_halted) m_mode = 0;
    end
  end

  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  task automatic neg();
    @(negedge clk1);
  endtask

  initial begin
    rst = 1; cpu_halted = 0; f_req = 0; d_req = 0; d_we = 0; ld_req = 0;
    f_addr = '0; d_addr = '0; ld_addr = '0; d_wdata = '0; ld_wdata = '0;
    step(); step();
    neg();
    chk("rst_mem_en", 32'(mem_en), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    // fetch-only read
    step(); rst = 0; f_req = 1; f_addr = 10'd5;
    neg();
    chk("fetch_gnt", 32'(f_gnt), 32'h1);
    chk("fetch_addr", 32'(mem_addr), 32'd5);
    step(); f_req = 0;
    neg();
    chk("fetch_rvalid", 32'(f_rvalid), 32'h1);
    chk("fetch_rdata", rdata, 32'h00222000);
    step();
    neg();
    chk("fetch_rvalid_once", 32'(f_rvalid), 32'h0);
    // sustained contention: four data grants, then one forced fetch
    step(); d_req = 1; f_req = 1; d_addr = 10'd7; f_addr = 10'd8;
    for (int k = 0; k < 10; k++) begin
      neg();
      chk("starve_f_gnt", 32'(f_gnt), 32'(k % 5 == 4));
      chk("starve_stall", 32'(stall_if), 32'(k % 5 != 4));
      step();
    end
    // store, then read it back
    f_req = 0; d_req = 1; d_we = 1; d_addr = 10'd3; d_wdata = 32'h0ce77800;
    neg();
    chk("store_we", 32'(mem_we), 32'h1);
    chk("store_wdata", mem_wdata, 32'h0ce77800);
    step(); d_we = 0;
    neg();
    chk("store_no_rvalid", 32'(d_rvalid), 32'h0);
    step(); d_req = 0;
    neg();
    chk("readback_rdata", rdata, 32'h0ce77800);
    // halt with a fetch outstanding, then load two words
    step(); f_req = 1; f_addr = 10'd5;
    neg();
    chk("pre_halt_f_gnt", 32'(f_gnt), 32'h1);
    step(); cpu_halted = 1; ld_req = 1; ld_addr = 10'd0; ld_wdata = 32'h2801000a;
    neg();
    chk("halt_no_gnt", 32'(f_gnt | ld_gnt), 32'h0);
    chk("halt_f_rvalid", 32'(f_rvalid), 32'h1);
    step();
    neg();
    chk("drain_no_ld", 32'(ld_gnt), 32'h0);
    step();
    neg();
    chk("load0_gnt", 32'(ld_gnt), 32'h1);
    chk("load0_wdata", mem_wdata, 32'h2801000a);
    step(); ld_addr = 10'd1; ld_wdata = 32'h28020014; d_req = 1;
    neg();
    chk("load1_gnt", 32'(ld_gnt), 32'h1);
    chk("load1_addr", 32'(mem_addr), 32'd1);
    chk("load_d_ignored", 32'(d_gnt), 32'h0);
    step(); ld_req = 0; d_req = 0; cpu_halted = 0;
    neg();
    chk("unhalt_still_load", 32'(f_gnt), 32'h0);
    step(); f_addr = 10'd0;
    neg();
    chk("resume_f_gnt", 32'(f_gnt), 32'h1);
    step(); f_req = 0;
    neg();
    chk("loaded_word", rdata, 32'h2801000a);
    // reset with a data read in flight
    step(); d_req = 1; d_addr = 10'd1;
    neg();
    chk("pre_rst_d_gnt", 32'(d_gnt), 32'h1);
    step(); rst = 1; d_req = 0;
    neg();
    chk("rst_d_rvalid", 32'(d_rvalid), 32'h0);
    chk("rst_rdata_zero", rdata, 32'h0);
    step(); rst = 0;
    neg();
    chk("post_rst_d_rvalid", 32'(d_rvalid), 32'h0);
    chk("post_rst_rdata", rdata, 32'h0);
    step(); f_req = 1; f_addr = 10'd9;
    neg();
    chk("post_rst_run", 32'(f_gnt), 32'h1);
    step(); f_req = 0;
    step(); step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
